// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the 2-digit scanned 7-segment display.
//   state_t    : digit-scan FSM states
//   SEG_TABLE  : active-high gfedcba patterns for digits 0..9 (bit 0 = segment a)
//   seg_pol/an_pol : map active-high segment/digit vectors onto the pin polarity
package seg7_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_UNITS = 2'd1,
        S_TENS  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic logic [6:0] seg_pol(input logic [6:0] pat, input logic active_low);
        return active_low ? ~pat : pat;
    endfunction

    function automatic logic [1:0] an_pol(input logic [1:0] en, input logic active_low);
        return active_low ? ~en : en;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD digit to active-high 7-segment pattern.
//   digit   : 4-bit code, 0..9 valid
//   pattern : gfedcba, bit 0 = a; codes above 9 give all segments dark (7'h00)
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = 7'h00;
        if (digit <= 4'd9)
            pattern = SEG_TABLE[digit];
    end

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: shows a 4-bit count (0..15) as two decimal digits on a
// multiplexed 2-digit 7-segment display. A prescaler sets the digit slot length,
// the scan FSM alternates units/tens, and the shown value is only updated at a
// frame boundary so a digit never changes partway through a frame.
//   clock       : system clock, posedge
//   clear_n     : synchronous active-low reset
//   value_in    : count to display
//   load        : capture value_in into the pending register
//   seg         : segments g..a (seg[0] = a), registered
//   an          : digit enables (an[0] = units, an[1] = tens), registered
//   frame_pulse : one-cycle pulse at each frame boundary, registered
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 50000,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic [3:0] value_in,
    input  logic       load,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_pulse
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [6:0] SEG_OFF = seg_pol(7'h00, ACTIVE_LOW);
    localparam logic [1:0] AN_OFF  = an_pol(2'b00, ACTIVE_LOW);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             boundary;
    state_t           state;
    logic [3:0]       pend_q;
    logic [3:0]       disp_q;
    logic             tens;
    logic [3:0]       units;
    logic [3:0]       dig_sel;
    logic [6:0]       pattern;

    // ---- prescaler and scan FSM ----
    assign tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
    // The boundary is the tick that moves the FSM into the units slot.
    assign boundary = tick && (state != S_UNITS);

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            div_cnt <= '0;
            state   <= S_IDLE;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                unique case (state)
                    S_IDLE:  state <= S_UNITS;
                    S_UNITS: state <= S_TENS;
                    S_TENS:  state <= S_UNITS;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // ---- sample and frame-synchronous display latch ----
    // disp_q takes the pending value as it stood before this edge, so a load
    // on the boundary edge is only shown from the following frame.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            pend_q      <= 4'd0;
            disp_q      <= 4'd0;
            frame_pulse <= 1'b0;
        end else begin
            if (load)
                pend_q <= value_in;
            if (boundary)
                disp_q <= pend_q;
            frame_pulse <= boundary;
        end
    end

    // ---- digit split and decode ----
    assign tens    = (disp_q >= 4'd10);
    assign units   = tens ? (disp_q - 4'd10) : disp_q;
    assign dig_sel = (state == S_TENS) ? {3'b000, tens} : units;

    seg7_decode u_decode (
        .digit   (dig_sel),
        .pattern (pattern)
    );

    // ---- output register (one cycle behind the FSM) ----
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            seg <= SEG_OFF;
            an  <= AN_OFF;
        end else begin
            unique case (state)
                S_UNITS: begin
                    an  <= an_pol(2'b01, ACTIVE_LOW);
                    seg <= seg_pol(pattern, ACTIVE_LOW);
                end
                S_TENS: begin
                    if (BLANK_LZ && !tens) begin
                        an  <= AN_OFF;
                        seg <= SEG_OFF;
                    end else begin
                        an  <= an_pol(2'b10, ACTIVE_LOW);
                        seg <= seg_pol(pattern, ACTIVE_LOW);
                    end
                end
                default: begin
                    an  <= AN_OFF;
                    seg <= SEG_OFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: directed bench for seg7_scan_display with CLK_DIV=4,
// active-low outputs. dut uses leading-zero blanking, dut_nb does not.
module tb_seg7_scan_display;

    logic       clock;
    logic       clear_n;
    logic [3:0] value_in;
    logic       load;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_pulse;
    logic [6:0] seg_nb;
    logic [1:0] an_nb;
    logic       frame_pulse_nb;

    int checks = 0;
    int errors = 0;
    int an_both_cnt = 0;

    // Hand-written active-low patterns for digits 0..9.
    localparam logic [6:0] LO [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    seg7_scan_display #(.CLK_DIV(4), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .value_in    (value_in),
        .load        (load),
        .seg         (seg),
        .an          (an),
        .frame_pulse (frame_pulse)
    );

    seg7_scan_display #(.CLK_DIV(4), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)) dut_nb (
        .clock       (clock),
        .clear_n     (clear_n),
        .value_in    (value_in),
        .load        (load),
        .seg         (seg_nb),
        .an          (an_nb),
        .frame_pulse (frame_pulse_nb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (clear_n && (an == 2'b00 || an_nb == 2'b00))
            an_both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [3:0] v);
        @(negedge clock);
        value_in = v;
        load     = 1'b1;
        @(negedge clock);
        load     = 1'b0;
    endtask

    // Bounded wait for the frame pulse; returns just after the pulse edge.
    task automatic wait_pulse(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (frame_pulse) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_pulse_seen"}, 32'(seen), 32'd1);
    endtask

    // Checks the units slot one cycle after the pulse and the tens slot 4 later.
    task automatic check_frame(input string tag, input int v);
        int t = (v >= 10) ? 1 : 0;
        int u = v - 10 * t;
        wait_pulse(tag);
        @(posedge clock);
        #1;
        chk({tag, "_u_an"},  32'(an),  32'(2'b10));
        chk({tag, "_u_seg"}, 32'(seg), 32'(LO[u]));
        chk({tag, "_u_seg_nb"}, 32'(seg_nb), 32'(LO[u]));
        chk({tag, "_u_fp"},  32'(frame_pulse), 32'd0);
        repeat (4) @(posedge clock);
        #1;
        if (t == 0) begin
            chk({tag, "_t_an"},  32'(an),  32'(2'b11));
            chk({tag, "_t_seg"}, 32'(seg), 32'(7'h7F));
        end else begin
            chk({tag, "_t_an"},  32'(an),  32'(2'b01));
            chk({tag, "_t_seg"}, 32'(seg), 32'(LO[t]));
        end
        chk({tag, "_t_an_nb"},  32'(an_nb),  32'(2'b01));
        chk({tag, "_t_seg_nb"}, 32'(seg_nb), 32'(LO[t]));
    endtask

    initial begin
        clear_n  = 1'b0;
        value_in = 4'd0;
        load     = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clock);
        #1;
        chk("rst_an",  32'(an),  32'(2'b11));
        chk("rst_seg", 32'(seg), 32'(7'h7F));
        chk("rst_fp",  32'(frame_pulse), 32'd0);
        @(negedge clock);
        clear_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock);
            #1;
            chk($sformatf("idle%0d_an", k),  32'(an),  32'(2'b11));
            chk($sformatf("idle%0d_seg", k), 32'(seg), 32'(7'h7F));
            chk($sformatf("idle%0d_fp", k),  32'(frame_pulse), (k == 4) ? 32'd1 : 32'd0);
        end
        @(posedge clock);
        #1;
        chk("first_u_an",  32'(an),  32'(2'b10));
        chk("first_u_seg", 32'(seg), 32'(7'h40));
        chk("first_fp",    32'(frame_pulse), 32'd0);

        // Load 13
        do_load(4'd13);
        check_frame("v13", 13);
        chk("v13_tens_79", 32'(seg), 32'(7'h79));

        // Load 5, blanked tens
        do_load(4'd5);
        check_frame("v5", 5);

        // Mid-frame load during the tens slot
        do_load(4'd12);
        check_frame("v12", 12);
        do_load(4'd7);
        chk("mid_t_an",  32'(an),  32'(2'b01));
        chk("mid_t_seg", 32'(seg), 32'(7'h79));
        check_frame("v7", 7);

        // Load on the boundary edge: old value stays for one more frame
        repeat (2) @(negedge clock);
        do_load(4'd9);
        chk("bnd_fp", 32'(frame_pulse), 32'd1);
        @(posedge clock);
        #1;
        chk("bnd_u_seg", 32'(seg), 32'(LO[7]));
        check_frame("bnd9", 9);

        // Counter sweep 0..15..0
        for (int i = 0; i < 31; i++) begin
            int v = (i <= 15) ? i : 30 - i;
            do_load(4'(v));
            check_frame($sformatf("sw%0d", v), v);
        end

        // Reset during the tens slot while showing 14
        do_load(4'd14);
        check_frame("v14", 14);
        @(negedge clock);
        clear_n = 1'b0;
        @(posedge clock);
        #1;
        chk("mrst_an",  32'(an),  32'(2'b11));
        chk("mrst_seg", 32'(seg), 32'(7'h7F));
        chk("mrst_fp",  32'(frame_pulse), 32'd0);
        @(negedge clock);
        clear_n = 1'b1;
        check_frame("mrst0", 0);

        chk("an_never_both", 32'(an_both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
